// File: rtl/ysyx_22040175_ifu.sv
// ysyx_22040175_ifu -- instruction fetch unit with prefetch FIFO.
//
// Owns the fetch PC and issues word requests to instruction memory. Responses
// return in order and are buffered together with their PCs. Buffered
// instructions are handed to decode over a valid/ready channel. A redirect
// reloads the fetch PC, flushes the buffer and discards the responses that
// are still outstanding at that point.
//
// Optional feature: define IFU_BYPASS_EN to let a response go straight to
// decode in the same cycle when the buffer is empty and nothing is being
// dropped. In the default build every response is registered first.
//
// Parameters:
//   XLEN      address / PC width
//   DEPTH     FIFO entries and maximum in-flight requests (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   redirect_valid/_pc        load a new fetch PC and flush (pc[1:0] ignored)
//   imem_req_valid/_ready     request handshake to instruction memory
//   imem_req_addr             word address of the offered request
//   imem_rsp_valid/_data      in-order response, no backpressure
//   inst_valid/_ready         instruction handshake to decode
//   inst, inst_pc             instruction word and its PC
module ysyx_22040175_ifu #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     fifo_inst [DEPTH];
  logic [XLEN-1:0] fifo_pc   [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;

  logic [CW:0]     credit_used;
  logic            req_fire;
  logic            rsp_keep;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] rsp_pc;
  logic [CW-1:0]   count_next;
  logic [CW-1:0]   inflight_next;
  logic            unused_pc_bits;

  assign unused_pc_bits = ^redirect_pc[1:0];

  // Buffered plus outstanding entries may never exceed DEPTH, so every
  // kept response is guaranteed a free FIFO slot.
  assign credit_used    = {1'b0, count} + {1'b0, inflight};
  assign imem_req_valid = (credit_used < DEPTH_W) && !rst;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Outstanding requests are consecutive words ending just below fetch_pc,
  // so the oldest one sits inflight words back. Only meaningful once drop
  // has reached zero, which is the only time the value is consumed.
  assign rsp_pc = fetch_pc - (XLEN'(inflight) << 2);

  // A response in a redirect cycle is stale and is discarded outright.
  assign rsp_keep = imem_rsp_valid && (drop == '0) && !redirect_valid;

`ifdef IFU_BYPASS_EN
  logic bypass_hit;

  assign bypass_hit = rsp_keep && (count == '0);
  assign inst_valid = (count != '0) || bypass_hit;
  assign inst       = bypass_hit ? imem_rsp_data : fifo_inst[rd_ptr];
  assign inst_pc    = bypass_hit ? rsp_pc : fifo_pc[rd_ptr];
  assign push       = rsp_keep && !(bypass_hit && inst_ready);
`else
  assign inst_valid = (count != '0);
  assign inst       = fifo_inst[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];
  assign push       = rsp_keep;
`endif

  assign pop = inst_ready && (count != '0);

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  assign inflight_next = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_next;
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        // Everything still outstanding after this cycle, including a request
        // accepted now at the old address, belongs to the abandoned path.
        drop     <= inflight_next;
      end else begin
        if (req_fire) begin
          fetch_pc <= fetch_pc + XLEN'(4);
        end
        if (imem_rsp_valid && (drop != '0)) begin
          drop <= drop - CW'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        count <= count_next;
      end
    end
  end

  // Storage is reset so inst/inst_pc read as zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (push) begin
      fifo_inst[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_ysyx_22040175_ifu.sv
module tb_ysyx_22040175_ifu;
  localparam int          XLEN   = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst;
  logic [XLEN-1:0] inst_pc;

  always #5 clk = ~clk;

  ysyx_22040175_ifu #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory model: in-order queue of accepted addresses with the cycle at
  // which each response becomes due.
  typedef struct { logic [31:0] addr; int due; } mem_t;
  mem_t mq[$];
  bit   mem_hold = 1'b0;
  bit   rand_lat = 1'b0;
  int   lat      = 1;

  // Reference model: the architectural instruction stream. Every handshake
  // must deliver the next sequential PC; a redirect restarts both streams.
  logic [31:0] exp_req;
  logic [31:0] exp_pc;
  bit          prev_redirect = 1'b0;

  bit          o_req_fire, o_req_valid, o_rsp, o_inst_fire, o_inst_valid;
  logic [31:0] o_req_addr, o_inst_pc;
  int          n_fire = 0;
  int          n_req  = 0;
  logic [31:0] fired_pc[$];

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0F0F;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic expect_seen(string name, bit seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: got none within bound, want event", name);
    end
  endtask

  task automatic step(bit rr, bit ir, bit rd, logic [31:0] rpc);
    @(posedge clk);
    #1;
    cyc++;
    if (!mem_hold && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_at(mq[0].addr);
      mq.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    imem_req_ready = rr;
    inst_ready     = ir;
    redirect_valid = rd;
    redirect_pc    = rpc;
    #2;
    o_req_valid  = imem_req_valid;
    o_req_addr   = imem_req_addr;
    o_req_fire   = imem_req_valid && rr;
    o_rsp        = imem_rsp_valid;
    o_inst_valid = inst_valid;
    o_inst_fire  = inst_valid && ir;
    o_inst_pc    = inst_pc;
    if (prev_redirect) check("valid_after_redirect", inst_valid, 0);
    if (o_inst_fire) begin
      check("inst_pc", inst_pc, exp_pc);
      check("inst_data", inst, word_at(exp_pc));
      exp_pc = exp_pc + 32'd4;
      n_fire++;
      fired_pc.push_back(inst_pc);
    end
    if (o_req_fire) begin
      check("req_addr", imem_req_addr, exp_req);
      exp_req = exp_req + 32'd4;
      n_req++;
      mq.push_back('{addr: imem_req_addr,
                     due: cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat)});
      check("outstanding_bound", (mq.size() <= DEPTH), 1);
    end
    if (rd) begin
      exp_req = {rpc[31:2], 2'b00};
      exp_pc  = {rpc[31:2], 2'b00};
    end
    prev_redirect = rd;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mq.delete();
    prev_redirect = 1'b0;
    mem_hold      = 1'b0;
    #1;
    check("rst_req_valid_now", imem_req_valid, 0);
    check("rst_inst_valid_now", inst_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_inst", inst, 0);
    check("rst_inst_pc", inst_pc, 0);
    rst     = 1'b0;
    exp_req = RST_PC;
    exp_pc  = RST_PC;
  endtask

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_addr;
    logic [31:0] exp_pc2;
  } vec_t;
  vec_t vecs[4];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, first_rsp, first_inst, first_req;
    bit rd;
    logic [31:0] tgt;

    vecs[0] = '{32'h8000_0103, 32'h8000_0100, 32'h8000_0104};
    vecs[1] = '{32'h0000_0002, 32'h0000_0000, 32'h0000_0004};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 32'h1234_567C};

    // Credit limit: four requests with no responses, then offer stops.
    do_reset();
    mem_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      check("t1_req_valid", o_req_valid, 1);
      check("t1_req_addr", o_req_addr, RST_PC + 32'(4 * i));
    end
    step(1, 1, 0, 0);
    check("t1_credit_stop", o_req_valid, 0);
    mem_hold = 1'b0;
    base = n_fire;
    repeat (10) step(0, 1, 0, 0);
    check("t1_drained", n_fire - base, 4);

    // Latency and steady-state throughput with 1-cycle memory.
    do_reset();
    lat = 1;
    first_rsp  = -1;
    first_inst = -1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      if (o_rsp && first_rsp < 0) first_rsp = cyc;
      if (o_inst_valid && first_inst < 0) first_inst = cyc;
    end
    expect_seen("t2_first_rsp", first_rsp >= 0);
    expect_seen("t2_first_inst", first_inst >= 0);
`ifdef IFU_BYPASS_EN
    check("t2_latency", first_inst - first_rsp, 0);
`else
    check("t2_latency", first_inst - first_rsp, 1);
`endif
    base = n_fire;
    repeat (20) step(1, 1, 0, 0);
    check("t2_throughput", n_fire - base, 20);

    // Backpressure: FIFO fills, requests stop, release drains in order.
    do_reset();
    base = n_req;
    repeat (8) step(1, 0, 0, 0);
    check("t3_full_stop", o_req_valid, 0);
    check("t3_head_valid", o_inst_valid, 1);
    check("t3_head_pc", o_inst_pc, RST_PC);
    check("t3_req_count", n_req - base, 4);
    base = n_fire;
    first_req = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0);
      if (i == 3) check("t3_four_out", n_fire - base, 4);
      if (o_req_fire && first_req == 0) begin
        first_req = 1;
        check("t3_resume_addr", o_req_addr, RST_PC + 32'h10);
      end
    end
    expect_seen("t3_resume", first_req == 1);

    // Redirect with two stale requests in flight.
    do_reset();
    mem_hold = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 1, 32'h8000_0103);
    step(1, 0, 0, 0);
    check("t4_req_valid", o_req_valid, 1);
    check("t4_req_addr", o_req_addr, 32'h8000_0100);
    mem_hold = 1'b0;
    base = fired_pc.size();
    for (int i = 0; i < 20 && fired_pc.size() == base; i++) step(1, 1, 0, 0);
    expect_seen("t4_first_inst", fired_pc.size() > base);
    if (fired_pc.size() > base) check("t4_first_pc", fired_pc[base], 32'h8000_0100);

    // Redirect, request accept, response and inst handshake in one cycle.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h8000_0200);
    check("t5_req_fire", o_req_fire, 1);
    check("t5_rsp", o_rsp, 1);
    check("t5_inst_fire", o_inst_fire, 1);
    check("t5_retired_pc", o_inst_pc, RST_PC);
    step(1, 1, 0, 0);
    check("t5_empty", o_inst_valid, 0);
    check("t5_new_addr", o_req_addr, 32'h8000_0200);
    base = fired_pc.size();
    for (int i = 0; i < 20 && fired_pc.size() == base; i++) step(1, 1, 0, 0);
    expect_seen("t5_first_inst", fired_pc.size() > base);
    if (fired_pc.size() > base) check("t5_first_pc", fired_pc[base], 32'h8000_0200);

    // Reset mid-stream with three entries buffered.
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    #1;
    check("t6_pre_inst_valid", inst_valid, 1);
    check("t6_pre_req_valid", imem_req_valid, 1);
    rst = 1'b1;
    #1;
    check("t6_inst_valid_drop", inst_valid, 0);
    check("t6_req_valid_drop", imem_req_valid, 0);
    do_reset();
    step(1, 1, 0, 0);
    check("t6_first_fire", o_req_fire, 1);
    check("t6_first_addr", o_req_addr, RST_PC);
    repeat (10) step(1, 1, 0, 0);

    // Table of redirect targets: alignment and wrap-around.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      step(0, 1, 1, vecs[v].rpc);
      step(1, 1, 0, 0);
      check("tab_req_valid", o_req_valid, 1);
      check("tab_req_addr", o_req_addr, vecs[v].exp_addr);
      base = fired_pc.size();
      for (int i = 0; i < 20 && fired_pc.size() < base + 2; i++) step(1, 1, 0, 0);
      expect_seen("tab_two_insts", fired_pc.size() >= base + 2);
      if (fired_pc.size() >= base + 2) begin
        check("tab_pc1", fired_pc[base], vecs[v].exp_addr);
        check("tab_pc2", fired_pc[base + 1], vecs[v].exp_pc2);
      end
    end

    // Random traffic against the stream model.
    do_reset();
    rand_lat = 1'b1;
    base = n_fire;
    for (int i = 0; i < 3000; i++) begin
      rd = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rd, tgt);
    end
    expect_seen("rand_progress", (n_fire - base) > 300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22040175_ifu.md
# ysyx_22040175_ifu

Parametrised instruction-fetch unit with a prefetch FIFO, replacing direct PC-to-instruction coupling in the core top. It owns the fetch PC, issues word requests to instruction memory over a valid/ready request channel, buffers in-order responses with their PCs, and presents them to decode over a valid/ready channel. Branch and jump redirects flush the buffer and discard stale in-flight responses.

## Interface
- XLEN, 32, address/PC width (matches `CPU_WIDTH`)
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, ≥2
- RESET_PC, 32'h8000_0000, first fetch address after reset (XLEN wide)

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- redirect_valid  in  1  load new fetch PC and flush
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  request offer
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  word address of request
- imem_rsp_valid  in  1  response data valid; no backpressure
- imem_rsp_data  in  32  instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes
- inst  out  32  instruction word
- inst_pc  out  XLEN  PC of `inst`

## Operation
- State: fetch_pc (XLEN); FIFO of DEPTH × {inst, pc}; rd/wr pointers; count, inflight, drop (each clog2(DEPTH)+1 bits).
- Request: imem_req_valid = (count + inflight < DEPTH) && !rst; imem_req_addr = fetch_pc. Transfer = valid && ready; on transfer, fetch_pc += 4 (wraps modulo 2^XLEN) and inflight++.
- Request channel is not sticky: valid may drop and addr may change without a transfer.
- Responses return in order, at least one cycle after acceptance. Each response decrements inflight. If drop > 0, the response is discarded and drop decrements. Otherwise it is written to the FIFO with pc = oldest outstanding address. The IFU keeps a pc shadow: a second DEPTH-entry queue, or rsp_pc = fetch_pc − 4·inflight.
- Decode handshake: inst_valid = (count > 0), or bypass (see Configuration). Transfer on inst_valid && inst_ready pops the head.
- Redirect (cycle N):
  - fetch_pc ← {redirect_pc[XLEN-1:2],2'b0}; FIFO cleared (count, pointers → 0).
  - drop ← inflight after the cycle's updates, including a request accepted in cycle N (that request used the old address) and excluding a response arriving in cycle N (that response is discarded directly).
  - An inst handshake in cycle N completes normally (the entry is consumed).
  - inst_valid stays as computed in cycle N; it is 0 in cycle N+1.
- Simultaneous push/pop at count == DEPTH is impossible by the credit rule. Push/pop at any other count is legal: count is unchanged.

## Timing
- Reset (async): fetch_pc = RESET_PC; count = inflight = drop = 0; pointers 0; imem_req_valid = 0, inst_valid = 0; inst and inst_pc = 0. The instruction memory must be reset by the same rst.
- First request is offered in the first cycle after rst deasserts.
- Latency without bypass: response in cycle N → inst_valid in cycle N+1.
- Steady state with single-cycle memory and inst_ready = 1: one instruction per cycle.
- After redirect in cycle N: imem_req_addr = redirect target in cycle N+1. The first valid inst has that PC.

## Configuration
- `IFU_BYPASS_EN` defined: when count == 0, drop == 0, no redirect, and imem_rsp_valid, the response drives inst/inst_pc/inst_valid in the same cycle. If inst_ready, it is not written to the FIFO; otherwise it is written.
- Undefined: every response is registered into the FIFO first, giving one-cycle latency. inst and inst_pc come straight from the FIFO head.

## Test plan
- Reset, imem_req_ready = 1, no responses → requests at 0x8000_0000, _0004, _0008, _000C, then imem_req_valid = 0 (inflight = 4).
- Memory with 1-cycle latency, inst_ready = 1 → inst_pc sequence 0x8000_0000, _0004, … one per cycle (bypass: inst_valid in the same cycle as the response).
- inst_ready = 0 → FIFO fills to 4, imem_req_valid = 0. Release → 4 instructions emitted in order, then fetching resumes at 0x8000_0010.
- 2 requests in flight, redirect to 0x8000_0103 → next request addr 0x8000_0100, both stale responses dropped, first inst_pc = 0x8000_0100.
- Same cycle: redirect, a request accept, a response, and an inst handshake → consumed entry retired, response discarded, drop = inflight (including the new request), FIFO empty in the next cycle.
- rst asserted mid-stream with 3 entries buffered → inst_valid and imem_req_valid drop immediately. After release, the first request is at 0x8000_0000.
